// File: rtl/lockin_iq_demod.sv
// Lock-in I/Q demodulator: multiplies ADC samples by offset-binary sin/cos references,
// integrates over 2^LOG2_N samples and presents each window result on a valid/ready port.
module lockin_iq_demod #(
    parameter int ADC_W  = 12,
    parameter int LOG2_N = 10,
    localparam int OUT_W = ADC_W + 8 + LOG2_N
) (
    input  logic                    sys_clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    clear,
    input  logic signed [ADC_W-1:0] adc_data,
    input  logic                    adc_valid,
    input  logic [7:0]              sin_ref,
    input  logic [7:0]              cos_ref,
    output logic signed [OUT_W-1:0] i_out,
    output logic signed [OUT_W-1:0] q_out,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    overrun
);

    localparam int PROD_W = ADC_W + 8;

    logic                     s1_v_q, s1_v_d;
    logic signed [ADC_W-1:0]  s1_adc_q, s1_adc_d;
    logic signed [7:0]        s1_sin_q, s1_sin_d;
    logic signed [7:0]        s1_cos_q, s1_cos_d;
    logic                     s2_v_q, s2_v_d;
    logic signed [PROD_W-1:0] prod_i_q, prod_i_d;
    logic signed [PROD_W-1:0] prod_q_q, prod_q_d;
    logic signed [OUT_W-1:0]  acc_i_q, acc_i_d;
    logic signed [OUT_W-1:0]  acc_q_q, acc_q_d;
    logic [LOG2_N-1:0]        cnt_q, cnt_d;
    logic signed [OUT_W-1:0]  i_out_q, i_out_d;
    logic signed [OUT_W-1:0]  q_out_q, q_out_d;
    logic                     out_valid_q, out_valid_d;
    logic                     overrun_q, overrun_d;

    logic signed [PROD_W-1:0] adc_ext, sin_ext, cos_ext;
    logic signed [OUT_W-1:0]  sum_i, sum_q;
    logic                     dump, xfer;

    always_comb begin
        // Flipping the MSB turns offset-binary into two's complement (128 -> 0).
        s1_v_d   = en & adc_valid;
        s1_adc_d = adc_data;
        s1_sin_d = {~sin_ref[7], sin_ref[6:0]};
        s1_cos_d = {~cos_ref[7], cos_ref[6:0]};

        adc_ext  = {{8{s1_adc_q[ADC_W-1]}}, s1_adc_q};
        sin_ext  = {{ADC_W{s1_sin_q[7]}}, s1_sin_q};
        cos_ext  = {{ADC_W{s1_cos_q[7]}}, s1_cos_q};
        s2_v_d   = en & s1_v_q;
        prod_i_d = adc_ext * sin_ext;
        prod_q_d = adc_ext * cos_ext;

        sum_i = acc_i_q + {{(OUT_W-PROD_W){prod_i_q[PROD_W-1]}}, prod_i_q};
        sum_q = acc_q_q + {{(OUT_W-PROD_W){prod_q_q[PROD_W-1]}}, prod_q_q};
        dump  = en & s2_v_q & (&cnt_q);
        xfer  = out_valid_q & out_ready;

        acc_i_d = acc_i_q;
        acc_q_d = acc_q_q;
        cnt_d   = cnt_q;
        if (!en || dump) begin
            acc_i_d = '0;
            acc_q_d = '0;
            cnt_d   = '0;
        end else if (s2_v_q) begin
            acc_i_d = sum_i;
            acc_q_d = sum_q;
            cnt_d   = cnt_q + 1'b1;
        end

        i_out_d     = i_out_q;
        q_out_d     = q_out_q;
        out_valid_d = out_valid_q;
        overrun_d   = overrun_q;
        if (dump) begin
            if (!out_valid_q || out_ready) begin
                i_out_d     = sum_i;
                q_out_d     = sum_q;
                out_valid_d = 1'b1;
            end else begin
                overrun_d   = 1'b1;
            end
        end else if (xfer) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v_q      <= 1'b0;
            s1_adc_q    <= '0;
            s1_sin_q    <= '0;
            s1_cos_q    <= '0;
            s2_v_q      <= 1'b0;
            prod_i_q    <= '0;
            prod_q_q    <= '0;
            acc_i_q     <= '0;
            acc_q_q     <= '0;
            cnt_q       <= '0;
            i_out_q     <= '0;
            q_out_q     <= '0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else if (clear) begin
            s1_v_q      <= 1'b0;
            s1_adc_q    <= '0;
            s1_sin_q    <= '0;
            s1_cos_q    <= '0;
            s2_v_q      <= 1'b0;
            prod_i_q    <= '0;
            prod_q_q    <= '0;
            acc_i_q     <= '0;
            acc_q_q     <= '0;
            cnt_q       <= '0;
            i_out_q     <= '0;
            q_out_q     <= '0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            s1_v_q      <= s1_v_d;
            s1_adc_q    <= s1_adc_d;
            s1_sin_q    <= s1_sin_d;
            s1_cos_q    <= s1_cos_d;
            s2_v_q      <= s2_v_d;
            prod_i_q    <= prod_i_d;
            prod_q_q    <= prod_q_d;
            acc_i_q     <= acc_i_d;
            acc_q_q     <= acc_q_d;
            cnt_q       <= cnt_d;
            i_out_q     <= i_out_d;
            q_out_q     <= q_out_d;
            out_valid_q <= out_valid_d;
            overrun_q   <= overrun_d;
        end
    end

    assign i_out     = i_out_q;
    assign q_out     = q_out_q;
    assign out_valid = out_valid_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_lockin_iq_demod.sv
// Bench for lockin_iq_demod (LOG2_N=4): directed scenarios plus random traffic, each cycle
// compared against a sample-queue reference model of the integrate-and-dump behaviour.
module tb_lockin_iq_demod;

    localparam int ADC_W  = 12;
    localparam int LOG2_N = 4;
    localparam int N      = 16;
    localparam int OUT_W  = ADC_W + 8 + LOG2_N;

    logic              sys_clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              en = 1'b0;
    logic              clear = 1'b0;
    logic [ADC_W-1:0]  adc_data = '0;
    logic              adc_valid = 1'b0;
    logic [7:0]        sin_ref = 8'd128;
    logic [7:0]        cos_ref = 8'd128;
    logic [OUT_W-1:0]  i_out;
    logic [OUT_W-1:0]  q_out;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic              overrun;

    lockin_iq_demod #(.ADC_W(ADC_W), .LOG2_N(LOG2_N)) dut (
        .sys_clk  (sys_clk),
        .rst_n    (rst_n),
        .en       (en),
        .clear    (clear),
        .adc_data (adc_data),
        .adc_valid(adc_valid),
        .sin_ref  (sin_ref),
        .cos_ref  (cos_ref),
        .i_out    (i_out),
        .q_out    (q_out),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .overrun  (overrun)
    );

    always #5 sys_clk = ~sys_clk;

    // Reference model: accepted samples wait in a queue and join the window two edges later.
    typedef struct {
        int a;
        int s;
        int c;
        int t;
    } samp_t;

    samp_t  pend[$];
    int     cyc_n = 0;
    int     w_cnt = 0;
    longint w_i = 0, w_q = 0, m_i = 0, m_q = 0;
    bit     m_ov = 0, m_over = 0;
    int     errors = 0, checks = 0;
    int     pulses = 0;
    longint last_i = 0, last_q = 0;

    function automatic void model_reset();
        pend.delete();
        w_cnt = 0; w_i = 0; w_q = 0;
        m_i = 0; m_q = 0; m_ov = 0; m_over = 0;
    endfunction

    function automatic void model_edge();
        bit     xfer, dump;
        longint d_i, d_q;
        samp_t  s, n;
        xfer = m_ov && out_ready;
        dump = 0; d_i = 0; d_q = 0;
        if (clear || !en) begin
            pend.delete();
            w_cnt = 0; w_i = 0; w_q = 0;
        end else begin
            while (pend.size() > 0 && pend[0].t + 2 <= cyc_n) begin
                s = pend.pop_front();
                w_i += longint'(s.a * s.s);
                w_q += longint'(s.a * s.c);
                w_cnt++;
                if (w_cnt == N) begin
                    dump = 1; d_i = w_i; d_q = w_q;
                    w_i = 0; w_q = 0; w_cnt = 0;
                end
            end
        end
        if (!clear && en && adc_valid) begin
            n.a = int'($signed(adc_data));
            n.s = int'(sin_ref) - 128;
            n.c = int'(cos_ref) - 128;
            n.t = cyc_n;
            pend.push_back(n);
        end
        if (clear) begin
            m_i = 0; m_q = 0; m_ov = 0; m_over = 0;
        end else if (dump) begin
            if (!m_ov || out_ready) begin
                m_i = d_i; m_q = d_q; m_ov = 1;
            end else begin
                m_over = 1;
            end
        end else if (xfer) begin
            m_ov = 0;
        end
        cyc_n++;
    endfunction

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("out_valid", {63'd0, out_valid}, {63'd0, m_ov});
        chk("i_out", $signed(i_out), m_i);
        chk("q_out", $signed(q_out), m_q);
        chk("overrun", {63'd0, overrun}, {63'd0, m_over});
        if (out_valid) begin
            pulses++;
            last_i = $signed(i_out);
            last_q = $signed(q_out);
        end
    endtask

    task automatic cyc(input bit e, input bit v, input logic [11:0] a, input logic [7:0] s,
                       input logic [7:0] c, input bit r, input bit cl);
        en = e; adc_valid = v; adc_data = a; sin_ref = s; cos_ref = c;
        out_ready = r; clear = cl;
        @(posedge sys_clk);
        if (rst_n) model_edge();
        @(negedge sys_clk);
        check_all();
    endtask

    task automatic idle(input int n, input bit r);
        for (int k = 0; k < n; k++) cyc(1, 0, 12'd0, 8'd128, 8'd128, r, 0);
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge sys_clk);
        check_all();
        rst_n = 1'b1;

        // Constant-amplitude window: 100 * 127 * 16.
        pulses = 0;
        for (int k = 0; k < 16; k++) cyc(1, 1, 12'd100, 8'd255, 8'd128, 1, 0);
        idle(5, 1);
        chk("s1_pulses", pulses, 1);
        chk("s1_i", last_i, 203200);
        chk("s1_q", last_q, 0);

        // Full-scale negative input against -128 references, two windows back to back.
        pulses = 0;
        for (int k = 0; k < 16; k++) cyc(1, 1, 12'h800, 8'd0, 8'd0, 1, 0);
        idle(4, 1);
        chk("s2_i_w1", last_i, 4194304);
        chk("s2_q_w1", last_q, 4194304);
        last_i = 0; last_q = 0;
        for (int k = 0; k < 16; k++) cyc(1, 1, 12'h800, 8'd0, 8'd0, 1, 0);
        idle(4, 1);
        chk("s2_i_w2", last_i, 4194304);
        chk("s2_q_w2", last_q, 4194304);
        chk("s2_pulses", pulses, 2);

        // Sparse valids: one sample every third cycle.
        pulses = 0; last_i = 0;
        for (int k = 0; k < 48; k++) cyc(1, (k % 3) == 0, 12'd100, 8'd255, 8'd128, 1, 0);
        idle(4, 1);
        chk("s3_i", last_i, 203200);
        chk("s3_pulses", pulses, 1);

        // Backpressure over two windows, then one transfer; overrun stays until clear.
        cyc(1, 0, 12'd0, 8'd128, 8'd128, 1, 1);
        for (int k = 0; k < 40; k++)
            cyc(1, 1, 12'($urandom), 8'($urandom), 8'($urandom), 0, 0);
        idle(3, 0);
        chk("s4_overrun", {63'd0, overrun}, 64'sd1);
        chk("s4_held_valid", {63'd0, out_valid}, 64'sd1);
        idle(1, 1);
        idle(2, 0);
        chk("s4_dropped", {63'd0, out_valid}, 64'sd0);
        chk("s4_sticky", {63'd0, overrun}, 64'sd1);
        cyc(1, 0, 12'd0, 8'd128, 8'd128, 0, 1);
        chk("s4_cleared", {63'd0, overrun}, 64'sd0);

        // Enable dropped mid-window: the first five samples must not count.
        pulses = 0; last_i = 0;
        for (int k = 0; k < 5; k++) cyc(1, 1, 12'd700, 8'd255, 8'd255, 1, 0);
        for (int k = 0; k < 10; k++) cyc(0, 1, 12'd700, 8'd255, 8'd255, 1, 0);
        for (int k = 0; k < 16; k++) cyc(1, 1, 12'd100, 8'd255, 8'd128, 1, 0);
        idle(5, 1);
        chk("s5_pulses", pulses, 1);
        chk("s5_i", last_i, 203200);

        // Asynchronous reset mid-window while a result is pending.
        for (int k = 0; k < 16; k++) cyc(1, 1, 12'd55, 8'd200, 8'd20, 0, 0);
        idle(3, 0);
        for (int k = 0; k < 7; k++) cyc(1, 1, 12'd55, 8'd200, 8'd20, 0, 0);
        chk("s6_pre_valid", {63'd0, out_valid}, 64'sd1);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        chk("s6_rst_i", $signed(i_out), 0);
        chk("s6_rst_q", $signed(q_out), 0);
        chk("s6_rst_valid", {63'd0, out_valid}, 64'sd0);
        chk("s6_rst_overrun", {63'd0, overrun}, 64'sd0);
        @(negedge sys_clk);
        rst_n = 1'b1;
        pulses = 0; last_i = 0;
        for (int k = 0; k < 16; k++) cyc(1, 1, 12'd100, 8'd255, 8'd128, 1, 0);
        idle(4, 1);
        chk("s6_pulses", pulses, 1);
        chk("s6_i", last_i, 203200);

        // Random traffic with occasional enable drops and clears.
        for (int k = 0; k < 600; k++)
            cyc(($urandom % 12) != 0, ($urandom % 4) != 0, 12'($urandom), 8'($urandom),
                8'($urandom), ($urandom % 3) != 0, ($urandom % 80) == 0);
        idle(4, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lockin_iq_demod.md
Name: lockin_iq_demod

Overview:
Consumer side of the NCO sin/cos reference path. It multiplies each ADC sample by the 8-bit offset-binary sin and cos reference words from the DDS ROMs. It integrates the products over a fixed window of 2^LOG2_N samples (integrate-and-dump) and presents I/Q results through a valid/ready handshake. It sits between the ADC capture logic and the lock-in output/readout stage.

Parameters:
ADC_W, 12, signed ADC sample width (two's complement).
LOG2_N, 10, log2 of the samples per integration window; window N = 2^LOG2_N.
OUT_W, ADC_W+8+LOG2_N, derived (localparam), width of the I/Q results; no overflow possible.

Ports:
sys_clk  in  1  system clock; all logic is on the rising edge.
rst_n  in  1  asynchronous active-low reset.
en  in  1  demodulation enable.
clear  in  1  synchronous clear of the window, pipeline, outputs and flag.
adc_data  in  ADC_W  signed ADC sample.
adc_valid  in  1  adc_data, sin_ref and cos_ref are valid this cycle.
sin_ref  in  8  in-phase reference, offset binary (128 = 0).
cos_ref  in  8  quadrature reference, offset binary (128 = 0).
i_out  out  OUT_W  signed integrated in-phase result.
q_out  out  OUT_W  signed integrated quadrature result.
out_valid  out  1  i_out/q_out hold a result that has not been consumed.
out_ready  in  1  downstream accepts the result.
overrun  out  1  sticky: a completed window was dropped.

Behaviour:
- Reset (rst_n low, async): all pipeline valids, the sample counter and both accumulators go to 0; i_out=0, q_out=0, out_valid=0, overrun=0.
- Reference conversion: signed ref = {~ref[7], ref[6:0]}. This maps 0 to -128, 128 to 0 and 255 to +127.
- Pipeline (a sample is accepted when en && adc_valid in cycle t):
  - Stage 1, end of t: register the sample and both converted refs, plus a valid bit.
  - Stage 2, end of t+1: register the signed products, each ADC_W+8 bits, full precision.
  - Stage 3, end of t+2: sign-extend each product to OUT_W and add it to its accumulator; the sample counter increments.
- Dump: when stage 3 adds the Nth product of the window (counter == N-1):
  - acc + product is the window result.
  - Both accumulators reset to 0 and the counter resets to 0 in the same edge.
  - If the result is accepted (see handshake), out_valid is high from cycle t+3.
- Accumulators are OUT_W signed; counter is LOG2_N bits and wraps N-1 -> 0 only at a dump.
- Gaps in adc_valid are allowed: only valid samples count, and bubbles propagate through the pipeline.
- Handshake:
  - A transfer occurs on a cycle with out_valid && out_ready; out_valid clears on the next edge unless a new dump lands in the same edge.
  - i_out/q_out are stable while out_valid=1.
  - Dump while out_valid=0, or while out_valid && out_ready: load the new result, out_valid=1.
  - Dump while out_valid && !out_ready: discard the new result, keep the old one, set overrun=1.
- en low: stage-1 capture is blocked, in-flight pipeline valids are cleared, and counter and accumulators are zeroed (the partial window is discarded). i_out/q_out/out_valid are held and the handshake still works. When en rises, a fresh window starts with the first accepted sample.
- clear: same effect as reset, but synchronous; it has priority over a dump and over a transfer in the same cycle.
- Reset or clear mid-window: the partial window is lost and no out_valid is produced for it.

Test Plan:
- LOG2_N=4, en=1, out_ready=1, adc_data=+100, sin_ref=255, cos_ref=128, 16 back-to-back valids -> one out_valid pulse 3 cycles after the 16th sample; i_out=203200, q_out=0.
- LOG2_N=4, adc_data=-2048, sin_ref=0, cos_ref=0, 16 samples -> i_out=q_out=+4194304; a second identical window gives the same values, confirming accumulators restart at 0.
- Same stimulus as the first scenario with adc_valid every 3rd cycle -> identical result; out_valid at 3 cycles after the 16th valid sample.
- out_ready=0 for 40 samples (2 windows) -> first result held unchanged and overrun=1 after the 2nd dump. Then out_ready=1 for one cycle -> out_valid drops; overrun stays 1 until clear.
- en deasserted after 5 samples for 10 cycles, then 16 samples of the first scenario's stimulus -> exactly one result of 203200; the first 5 samples are not included.
- rst_n pulsed low asynchronously mid-window with out_valid=1 -> all outputs 0 immediately; the next 16 samples produce a correct full result.
